// File: rtl/task2_2_fa.sv
// Single-bit full adder with registered outputs and an exhaustive built-in self-test.
// The BIST drives its own copy of the adder logic from a 3-bit index and checks it against a ROM.
module task2_2_fa (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       bist_start,
    output logic       X,
    output logic       Y,
    output logic       X_q,
    output logic       Y_q,
    output logic       bist_busy,
    output logic       bist_done,
    output logic       bist_pass,
    output logic [3:0] bist_err_cnt
);

    typedef enum logic {StIdle, StRun} bist_state_e;

    // Golden truth table, bit i holds the result for ABC = i.
    localparam logic [7:0] SumRom   = 8'b1001_0110;
    localparam logic [7:0] CarryRom = 8'b1110_1000;

    bist_state_e state;
    logic [2:0]  idx;
    logic        bist_x;
    logic        bist_y;
    logic        mismatch;
    logic [3:0]  err_next;

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    always_comb begin
        {Y, X}           = full_add(A, B, C);
        {bist_y, bist_x} = full_add(idx[2], idx[1], idx[0]);
        mismatch         = (bist_x != SumRom[idx]) || (bist_y != CarryRom[idx]);
        err_next         = bist_err_cnt;
        if (mismatch && (bist_err_cnt < 4'd8)) begin
            err_next = bist_err_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            X_q <= 1'b0;
            Y_q <= 1'b0;
        end else begin
            X_q <= X;
            Y_q <= Y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            idx          <= 3'd0;
            bist_busy    <= 1'b0;
            bist_done    <= 1'b0;
            bist_pass    <= 1'b0;
            bist_err_cnt <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bist_start) begin
                        state        <= StRun;
                        idx          <= 3'd0;
                        bist_busy    <= 1'b1;
                        bist_done    <= 1'b0;
                        bist_pass    <= 1'b0;
                        bist_err_cnt <= 4'd0;
                    end
                end
                StRun: begin
                    bist_err_cnt <= err_next;
                    if (idx == 3'd7) begin
                        // Verdict includes the final vector's compare result.
                        state     <= StIdle;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_pass <= (err_next == 4'd0);
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_task2_2_fa.sv
// Self-checking bench for task2_2_fa: random and exhaustive adder checks against an
// arithmetic model, plus BIST sequencing, abort and start-collision scenarios.
module tb_task2_2_fa;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic       bist_start = 1'b0;
    logic       X, Y, X_q, Y_q, bist_busy, bist_done, bist_pass;
    logic [3:0] bist_err_cnt;

    int errors = 0;
    int checks = 0;

    task2_2_fa dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .C            (C),
        .bist_start   (bist_start),
        .X            (X),
        .Y            (Y),
        .X_q          (X_q),
        .Y_q          (Y_q),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .bist_pass    (bist_pass),
        .bist_err_cnt (bist_err_cnt)
    );

    // Clock only runs when enabled so the combinational sweep sees no edges.
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [1:0] model_add(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_comb();
        logic [1:0] exp;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {A, B, C} = v;
            #10;
            exp = model_add(v[2], v[1], v[0]);
            checks++;
            if (X !== exp[0]) begin
                errors++;
                $display("FAIL comb_x abc=%b got=%b exp=%b", v, X, exp[0]);
            end
            checks++;
            if (Y !== exp[1]) begin
                errors++;
                $display("FAIL comb_y abc=%b got=%b exp=%b", v, Y, exp[1]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            v = 3'($urandom);
            {A, B, C} = v;
            #1;
            exp = model_add(v[2], v[1], v[0]);
            checks++;
            if ({Y, X} !== exp) begin
                errors++;
                $display("FAIL comb_rand abc=%b got=%b%b exp=%b", v, Y, X, exp);
            end
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({X_q, Y_q, bist_busy, bist_done, bist_pass, bist_err_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL reset got xq=%b yq=%b busy=%b done=%b pass=%b err=%0d exp all 0",
                     X_q, Y_q, bist_busy, bist_done, bist_pass, bist_err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_registered();
        logic [1:0] exp;
        logic [2:0] v;
        {A, B, C} = 3'b011;
        tick();
        checks++;
        if ({Y_q, X_q} !== 2'b10) begin
            errors++;
            $display("FAIL reg_011 got yq=%b xq=%b exp yq=1 xq=0", Y_q, X_q);
        end
        {A, B, C} = 3'b111;
        tick();
        checks++;
        if ({Y_q, X_q} !== 2'b11) begin
            errors++;
            $display("FAIL reg_111 got yq=%b xq=%b exp yq=1 xq=1", Y_q, X_q);
        end
        for (int i = 0; i < 16; i++) begin
            v = 3'($urandom);
            {A, B, C} = v;
            exp = model_add(v[2], v[1], v[0]);
            tick();
            checks++;
            if ({Y_q, X_q} !== exp) begin
                errors++;
                $display("FAIL reg_rand abc=%b got=%b%b exp=%b", v, Y_q, X_q, exp);
            end
        end
    endtask

    // Pulses start; optionally re-pulses it at busy cycle 3. Counts busy cycles with a bound.
    task automatic run_bist(input bit collide, output int busy_cycles);
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        busy_cycles = 0;
        checks++;
        if (bist_done !== 1'b0) begin
            errors++;
            $display("FAIL bist_done_cleared got=%b exp=0", bist_done);
        end
        for (int k = 0; k < 20 && bist_busy === 1'b1; k++) begin
            busy_cycles++;
            A = 1'($urandom);
            B = 1'($urandom);
            C = 1'($urandom);
            bist_start = collide && (busy_cycles == 3);
            tick();
        end
        bist_start = 1'b0;
    endtask

    task automatic test_bist_pass();
        int n;
        run_bist(1'b0, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bist_busy_len got=%0d exp=8", n);
        end
        checks++;
        if ({bist_done, bist_pass, bist_err_cnt} !== 6'b11_0000) begin
            errors++;
            $display("FAIL bist_result got done=%b pass=%b err=%0d exp done=1 pass=1 err=0",
                     bist_done, bist_pass, bist_err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            {A, B, C} = 3'($urandom);
            tick();
        end
        checks++;
        if ({bist_busy, bist_done, bist_pass} !== 3'b011) begin
            errors++;
            $display("FAIL bist_hold got busy=%b done=%b pass=%b exp 0 1 1",
                     bist_busy, bist_done, bist_pass);
        end
    endtask

    task automatic test_start_during_run();
        int n;
        int late_busy;
        run_bist(1'b1, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL collide_len got=%0d exp=8", n);
        end
        late_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (bist_busy !== 1'b0) late_busy++;
            tick();
        end
        checks++;
        if (late_busy != 0) begin
            errors++;
            $display("FAIL collide_restart got busy_cycles=%0d exp=0", late_busy);
        end
        checks++;
        if ({bist_done, bist_pass} !== 2'b11) begin
            errors++;
            $display("FAIL collide_result got done=%b pass=%b exp 1 1", bist_done, bist_pass);
        end
    endtask

    task automatic test_reset_mid();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bist_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got=%b exp=1", bist_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bist_busy, bist_done, bist_pass, bist_err_cnt} !== 7'd0) begin
            errors++;
            $display("FAIL midrst got busy=%b done=%b pass=%b err=%0d exp all 0",
                     bist_busy, bist_done, bist_pass, bist_err_cnt);
        end
        tick();
        checks++;
        if (bist_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_resume got busy=%b exp=0", bist_busy);
        end
    endtask

    task automatic test_rst_and_start();
        int seen_busy;
        {A, B, C} = 3'b111;
        tick();
        rst = 1'b1;
        bist_start = 1'b1;
        tick();
        rst = 1'b0;
        bist_start = 1'b0;
        checks++;
        if ({X_q, Y_q, bist_busy, bist_done, bist_pass, bist_err_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL rst_start got xq=%b yq=%b busy=%b done=%b pass=%b err=%0d exp all 0",
                     X_q, Y_q, bist_busy, bist_done, bist_pass, bist_err_cnt);
        end
        seen_busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (bist_busy !== 1'b0) seen_busy++;
            tick();
        end
        checks++;
        if (seen_busy != 0) begin
            errors++;
            $display("FAIL rst_start_busy got busy_cycles=%0d exp=0", seen_busy);
        end
    endtask

    initial begin
        test_comb();
        test_reset();
        test_registered();
        test_bist_pass();
        test_start_during_run();
        test_reset_mid();
        test_rst_and_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
